// File: rtl/calc_port_pkg.sv
// Shared types and constants for the calc_port request engine.
package calc_port_pkg;

  localparam int unsigned NUM_TAGS = 4;

  typedef enum logic [3:0] {
    CmdNop = 4'd0,
    CmdAdd = 4'd1,
    CmdSub = 4'd2,
    CmdShl = 4'd5,
    CmdShr = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RespNone = 2'b00,
    RespOk   = 2'b01,
    RespErr  = 2'b10,
    RespRsvd = 2'b11
  } resp_e;

  typedef enum logic {
    StIdle,
    StOp2
  } state_e;

  typedef struct packed {
    logic        valid;
    resp_e       resp;
    logic [31:0] result;
    logic [2:0]  timer;
  } pend_entry_t;

endpackage

// File: rtl/calc_port_if.sv
// Request/response stream bundle between the stimulus port and calc_port_engine.
interface calc_port_if;
  logic [0:3]  req_cmd_in;
  logic [0:1]  req_tag_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic [0:1]  out_tag;
  logic        dup_err;

  modport master (
    output req_cmd_in, req_tag_in, req_data_in,
    input  out_resp, out_data, out_tag, dup_err
  );

  modport slave (
    input  req_cmd_in, req_tag_in, req_data_in,
    output out_resp, out_data, out_tag, dup_err
  );
endinterface

// File: rtl/calc_port_alu.sv
// Combinational datapath producing {resp, result} for one request.
// The shifter is only built when CALC_PORT_SHIFT_EN is defined.
module calc_port_alu
  import calc_port_pkg::*;
(
  input  logic [3:0]  cmd,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output resp_e       resp,
  output logic [31:0] result
);

  logic [32:0] sum;

  always_comb begin
    resp   = RespErr;
    result = '0;
    sum    = {1'b0, op1} + {1'b0, op2};
    case (cmd)
      CmdAdd: begin
        if (!sum[32]) begin
          resp   = RespOk;
          result = sum[31:0];
        end
      end
      CmdSub: begin
        if (op1 >= op2) begin
          resp   = RespOk;
          result = op1 - op2;
        end
      end
`ifdef CALC_PORT_SHIFT_EN
      CmdShl: begin
        resp   = RespOk;
        result = op1 << op2[4:0];
      end
      CmdShr: begin
        resp   = RespOk;
        result = op1 >> op2[4:0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_port_engine.sv
// Two-cycle command/operand intake feeding a 4-entry tagged pending table with out-of-order
// responses. Shift commands are built only when CALC_PORT_SHIFT_EN is defined.
module calc_port_engine
  import calc_port_pkg::*;
#(
  parameter int unsigned ADD_LAT   = 3,
  parameter int unsigned SHIFT_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  calc_port_if.slave   bus
);

  if (ADD_LAT < 1 || ADD_LAT > 7 || SHIFT_LAT < 1 || SHIFT_LAT > 7) begin : g_bad_lat
    $error("calc_port_engine: latency parameters must be in 1..7");
  end

  state_e      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  tag_q, tag_d;
  logic [31:0] op1_q, op1_d;
  logic        drop_q, drop_d;
  pend_entry_t pend_q [NUM_TAGS];
  pend_entry_t pend_d [NUM_TAGS];
  resp_e       out_resp_q, out_resp_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  out_tag_q, out_tag_d;
  logic        dup_err_q, dup_err_d;

  logic [3:0]  req_cmd;
  logic [1:0]  req_tag;
  logic [31:0] req_data;
  logic        grant_valid;
  logic [1:0]  grant_tag;
  logic        in_flight;
  logic [2:0]  lat;
  resp_e       alu_resp;
  logic [31:0] alu_result;

  assign req_cmd  = bus.req_cmd_in;
  assign req_tag  = bus.req_tag_in;
  assign req_data = bus.req_data_in;

  calc_port_alu u_alu (
    .cmd    (cmd_q),
    .op1    (op1_q),
    .op2    (req_data),
    .resp   (alu_resp),
    .result (alu_result)
  );

  always_comb begin
    lat = 3'd1;
    case (cmd_q)
      CmdAdd, CmdSub: lat = 3'(ADD_LAT);
`ifdef CALC_PORT_SHIFT_EN
      CmdShl, CmdShr: lat = 3'(SHIFT_LAT);
`endif
      default: ;
    endcase
  end

  // Ready one cycle early (timer <= 1) so the registered output lands LAT edges after loading.
  always_comb begin
    grant_valid = 1'b0;
    grant_tag   = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (pend_q[i].valid && pend_q[i].timer <= 3'd1) begin
        grant_valid = 1'b1;
        grant_tag   = 2'(i);
      end
    end
  end

  assign in_flight = pend_q[req_tag].valid && !(grant_valid && grant_tag == req_tag);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tag_d      = tag_q;
    op1_d      = op1_q;
    drop_d     = drop_q;
    dup_err_d  = dup_err_q;
    out_resp_d = RespNone;
    out_data_d = '0;
    out_tag_d  = '0;

    for (int i = 0; i < NUM_TAGS; i++) begin
      pend_d[i] = pend_q[i];
      if (pend_q[i].valid && pend_q[i].timer != 3'd0) begin
        pend_d[i].timer = pend_q[i].timer - 3'd1;
      end
    end

    if (grant_valid) begin
      out_resp_d        = pend_q[grant_tag].resp;
      out_data_d        = pend_q[grant_tag].result;
      out_tag_d         = grant_tag;
      pend_d[grant_tag] = '0;
    end

    case (state_q)
      StIdle: begin
        if (req_cmd != CmdNop) begin
          cmd_d     = req_cmd;
          tag_d     = req_tag;
          op1_d     = req_data;
          drop_d    = in_flight;
          dup_err_d = dup_err_q | in_flight;
          state_d   = StOp2;
        end
      end
      StOp2: begin
        // A load here overrides a same-cycle free of this entry.
        if (!drop_q) begin
          pend_d[tag_q] = '{valid: 1'b1, resp: alu_resp, result: alu_result, timer: lat};
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      tag_q      <= '0;
      op1_q      <= '0;
      drop_q     <= 1'b0;
      dup_err_q  <= 1'b0;
      out_resp_q <= RespNone;
      out_data_q <= '0;
      out_tag_q  <= '0;
      for (int i = 0; i < NUM_TAGS; i++) pend_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tag_q      <= tag_d;
      op1_q      <= op1_d;
      drop_q     <= drop_d;
      dup_err_q  <= dup_err_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      for (int i = 0; i < NUM_TAGS; i++) pend_q[i] <= pend_d[i];
    end
  end

  assign bus.out_resp = out_resp_q;
  assign bus.out_data = out_data_q;
  assign bus.out_tag  = out_tag_q;
  assign bus.dup_err  = dup_err_q;

endmodule

// File: tb/tb_calc_port_engine.sv
// Self-checking bench for calc_port_engine: directed vector table, corner sequences and a
// randomized run against a due-cycle reference model. Honours CALC_PORT_SHIFT_EN.
module tb_calc_port_engine;

`ifdef CALC_PORT_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif
  localparam int ADD_L   = 3;
  localparam int SHIFT_L = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  calc_port_if bus ();

  calc_port_engine #(.ADD_LAT(ADD_L), .SHIFT_LAT(SHIFT_L)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  longint edge_n = 0;

  // Reference model: pending requests carry an absolute due edge instead of a timer.
  bit          m_busy;
  logic [3:0]  m_cmd;
  logic [1:0]  m_tag;
  logic [31:0] m_op1;
  bit          m_drop;
  bit          mv [4];
  longint      mdue [4];
  logic [1:0]  mr [4];
  logic [31:0] md [4];
  logic [1:0]  e_resp;
  logic [31:0] e_data;
  logic [1:0]  e_tag;
  bit          e_dup;

  function automatic int lat_of(input logic [3:0] c);
    if (c == 4'd1 || c == 4'd2) return ADD_L;
    if (SHIFT_EN && (c == 4'd5 || c == 4'd6)) return SHIFT_L;
    return 1;
  endfunction

  function automatic void calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               output logic [1:0] r, output logic [31:0] d);
    logic [63:0] s;
    int amt;
    r = 2'b10;
    d = '0;
    s = {32'b0, a} + {32'b0, b};
    amt = int'(b % 32);
    if (c == 4'd1 && s <= 64'hFFFF_FFFF) begin
      r = 2'b01; d = s[31:0];
    end else if (c == 4'd2 && a >= b) begin
      r = 2'b01; d = a - b;
    end else if (SHIFT_EN && c == 4'd5) begin
      r = 2'b01; d = a << amt;
    end else if (SHIFT_EN && c == 4'd6) begin
      r = 2'b01; d = a >> amt;
    end
  endfunction

  task automatic model_edge();
    logic [3:0] c;
    logic [1:0] t;
    logic [31:0] dd;
    int hit;
    c = bus.req_cmd_in; t = bus.req_tag_in; dd = bus.req_data_in;
    e_resp = '0; e_data = '0; e_tag = '0;
    if (!rst) begin
      m_busy = 0; e_dup = 0;
      for (int i = 0; i < 4; i++) mv[i] = 0;
      return;
    end
    hit = -1;
    for (int i = 3; i >= 0; i--) if (mv[i] && mdue[i] <= edge_n) hit = i;
    if (hit >= 0) begin
      e_resp = mr[hit]; e_data = md[hit]; e_tag = 2'(hit); mv[hit] = 0;
    end
    if (m_busy) begin
      if (!m_drop) begin
        mv[m_tag] = 1;
        mdue[m_tag] = edge_n + lat_of(m_cmd);
        calc(m_cmd, m_op1, dd, mr[m_tag], md[m_tag]);
      end
      m_busy = 0;
    end else if (c != 0) begin
      m_busy = 1; m_cmd = c; m_tag = t; m_op1 = dd;
      m_drop = mv[t];
      if (m_drop) e_dup = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] t, input logic [31:0] d);
    bus.req_cmd_in = c; bus.req_tag_in = t; bus.req_data_in = d;
  endtask

  task automatic issue(input logic [3:0] c, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] b);
    drive(c, t, a); step();
    drive(4'd0, 2'd0, b); step();
    drive(4'd0, 2'd0, 32'd0);
  endtask

  task automatic rst_dut();
    rst = 1'b0; drive(4'd0, 2'd0, 32'd0);
    step(); step();
    rst = 1'b1;
  endtask

  function automatic logic [63:0] outs();
    return {29'd0, bus.dup_err, bus.out_resp, bus.out_tag, bus.out_data};
  endfunction

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int k, n2;
    bit got;
    logic [31:0] d2;
    vecs[0] = '{4'd1, 2'd2, 32'h5, 32'h3, 2'b01, 32'h8, 3};
    vecs[1] = '{4'd1, 2'd1, 32'hFFFF_FFFF, 32'h1, 2'b10, 32'h0, 3};
    vecs[2] = '{4'd2, 2'd0, 32'h3, 32'h5, 2'b10, 32'h0, 3};
    vecs[3] = '{4'd2, 2'd3, 32'h9, 32'h4, 2'b01, 32'h5, 3};
    vecs[4] = '{4'd3, 2'd2, 32'h7, 32'h7, 2'b10, 32'h0, 1};
    if (SHIFT_EN) begin
      vecs[5] = '{4'd5, 2'd0, 32'h1, 32'd31, 2'b01, 32'h8000_0000, 2};
      vecs[6] = '{4'd6, 2'd1, 32'h8000_0000, 32'd4, 2'b01, 32'h0800_0000, 2};
      vecs[7] = '{4'd5, 2'd3, 32'hF, 32'h24, 2'b01, 32'hF0, 2};
    end else begin
      vecs[5] = '{4'd5, 2'd0, 32'h1, 32'd31, 2'b10, 32'h0, 1};
      vecs[6] = '{4'd6, 2'd1, 32'h8000_0000, 32'd4, 2'b10, 32'h0, 1};
      vecs[7] = '{4'd5, 2'd3, 32'hF, 32'h24, 2'b10, 32'h0, 1};
    end

    drive(4'd0, 2'd0, 32'd0);
    rst_dut();
    check("reset_outputs", outs(), 64'd0);

    for (int v = 0; v < 8; v++) begin
      rst_dut();
      issue(vecs[v].cmd, vecs[v].tag, vecs[v].op1, vecs[v].op2);
      k = 0; got = 0;
      while (k < 10 && !got) begin
        step(); k++;
        if (bus.out_resp != 2'b00) got = 1;
      end
      check($sformatf("vec%0d_latency", v), 64'(k), 64'(vecs[v].lat));
      check($sformatf("vec%0d_resp", v), 64'(bus.out_resp), 64'(vecs[v].resp));
      check($sformatf("vec%0d_data", v), 64'(bus.out_data), 64'(vecs[v].data));
      check($sformatf("vec%0d_tag", v), 64'(bus.out_tag), 64'(vecs[v].tag));
      step();
      check($sformatf("vec%0d_one_cycle", v), outs(), 64'd0);
    end

    // Add tag 0, then shift right tag 1 two cycles later.
    rst_dut();
    issue(4'd1, 2'd0, 32'd10, 32'd20);
    issue(4'd6, 2'd1, 32'h8000_0000, 32'd4);
    step();
    check("order_first", outs(), {29'd0, 1'b0, 2'b01, 2'd0, 32'd30});
    step();
    check("order_second", outs(),
          SHIFT_EN ? {29'd0, 1'b0, 2'b01, 2'd1, 32'h0800_0000} : {29'd0, 1'b0, 2'b10, 2'd1, 32'd0});

    // Tags 3 and 1 become ready on the same edge.
    rst_dut();
    issue(4'd1, 2'd3, 32'd1, 32'd2);
    issue(4'd3, 2'd1, 32'd0, 32'd0);
    step();
    check("tie_low_tag", outs(), {29'd0, 1'b0, 2'b10, 2'd1, 32'd0});
    step();
    check("tie_next", outs(), {29'd0, 1'b0, 2'b01, 2'd3, 32'd3});

    // Duplicate tag while busy.
    rst_dut();
    issue(4'd1, 2'd2, 32'd100, 32'd200);
    issue(4'd1, 2'd2, 32'd7, 32'd8);
    check("dup_set", 64'(bus.dup_err), 64'd1);
    n2 = 0; d2 = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_resp != 2'b00 && bus.out_tag == 2'd2) begin
        n2++; d2 = bus.out_data;
      end
    end
    check("dup_one_resp", 64'(n2), 64'd1);
    check("dup_data", 64'(d2), 64'd300);
    check("dup_sticky", 64'(bus.dup_err), 64'd1);

    // Reset with requests pending and a transfer mid-way.
    rst_dut();
    issue(4'd1, 2'd0, 32'd1, 32'd1);
    issue(4'd2, 2'd1, 32'd9, 32'd1);
    drive(4'd1, 2'd2, 32'd5); rst = 1'b0;
    step();
    rst = 1'b1; drive(4'd0, 2'd0, 32'd3);
    n2 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (outs() != 64'd0) n2++;
    end
    check("reset_discard", 64'(n2), 64'd0);

    // Randomized run against the reference model.
    rst_dut();
    for (int i = 0; i < 800; i++) begin
      logic [3:0] c;
      logic [31:0] d;
      case ($urandom_range(0, 9))
        0, 1, 2: c = 4'd0;
        3, 4:    c = 4'd1;
        5:       c = 4'd2;
        6:       c = 4'd5;
        7:       c = 4'd6;
        8:       c = 4'd3;
        default: c = 4'd15;
      endcase
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      drive(c, 2'($urandom_range(0, 3)), d);
      step();
      check($sformatf("rand%0d", i), outs(), {29'd0, e_dup, e_resp, e_tag, e_data});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
